// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Gowin SDRAM HS controller between burst clients.
// The owner keeps the command interface for a whole transaction; refresh is scheduled here.
module sdram_arbiter #(
    parameter int Requesters              = 2,
    parameter int AutoRefreshPeriodCycles = 600
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [Requesters-1:0]      req,
    output logic [Requesters-1:0]      grant,
    output logic                       refresh_pending,
    input  logic [Requesters-1:0]      c_cmd_en,
    input  logic [Requesters*3-1:0]    c_cmd,
    input  logic [Requesters*21-1:0]   c_addr,
    input  logic [Requesters*32-1:0]   c_data,
    input  logic [Requesters*8-1:0]    c_data_len,
    output logic [Requesters-1:0]      c_cmd_ack,
    output logic [31:0]                c_data_out,
    output logic                       I_sdrc_cmd_en,
    output logic [2:0]                 I_sdrc_cmd,
    output logic [20:0]                I_sdrc_addr,
    output logic [31:0]                I_sdrc_data,
    output logic [7:0]                 I_sdrc_data_len,
    input  logic [31:0]                O_sdrc_data,
    input  logic                       O_sdrc_init_done,
    input  logic                       O_sdrc_cmd_ack
);

    localparam int          PW          = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam logic [15:0] PERIOD      = 16'(AutoRefreshPeriodCycles);
    localparam logic [15:0] CNT_RESET   = 16'(AutoRefreshPeriodCycles + 1);
    localparam logic [2:0]  CMD_REFRESH = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_GRANTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [Requesters-1:0]   grant_q, grant_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [15:0]             counter_q, counter_d;
    logic                    ref_en_q, ref_en_d;
    logic [2:0]              ref_cmd_q, ref_cmd_d;

    logic                    win_found_s;
    logic [PW-1:0]           win_idx_s;
    logic [PW-1:0]           scan_idx_s;
    logic                    sel_cmd_en_s;
    logic [2:0]              sel_cmd_s;
    logic [20:0]             sel_addr_s;
    logic [31:0]             sel_data_s;
    logic [7:0]              sel_len_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign refresh_pending = (counter_q > PERIOD);
    assign grant           = grant_q;
    assign c_data_out      = O_sdrc_data;

    // Round-robin scan: first requester at or after rr_ptr, wrapping modulo the client count
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = '0;
        for (int i = 0; i < Requesters; i++) begin
            scan_idx_s = PW'((int'(rr_ptr_q) + i) % Requesters);
            if (!win_found_s && req[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // AND-OR mux of the owner's command fields
    always_comb begin
        sel_cmd_en_s = 1'b0;
        sel_cmd_s    = 3'b000;
        sel_addr_s   = 21'd0;
        sel_data_s   = 32'd0;
        sel_len_s    = 8'd0;
        for (int i = 0; i < Requesters; i++) begin
            sel_cmd_en_s = sel_cmd_en_s | (c_cmd_en[i] & req[i] & (owner_q == PW'(i)));
            sel_cmd_s    = sel_cmd_s  | (c_cmd[i*3 +: 3]       & {3{owner_q == PW'(i)}});
            sel_addr_s   = sel_addr_s | (c_addr[i*21 +: 21]    & {21{owner_q == PW'(i)}});
            sel_data_s   = sel_data_s | (c_data[i*32 +: 32]    & {32{owner_q == PW'(i)}});
            sel_len_s    = sel_len_s  | (c_data_len[i*8 +: 8]  & {8{owner_q == PW'(i)}});
        end
    end

    // Next-state: refresh scheduling, grant selection and release
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        counter_d = counter_q;
        ref_en_d  = 1'b0;
        ref_cmd_d = 3'b000;
        case (state_q)
            ST_IDLE: begin
                counter_d = sat_inc(counter_q);
                if (!O_sdrc_init_done) begin
                    state_d = ST_IDLE;
                end else if (refresh_pending) begin
                    ref_en_d  = 1'b1;
                    ref_cmd_d = CMD_REFRESH;
                    state_d   = ST_REFRESH;
                end else if (win_found_s) begin
                    grant_d            = '0;
                    grant_d[win_idx_s] = 1'b1;
                    owner_d            = win_idx_s;
                    state_d            = ST_GRANTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (O_sdrc_cmd_ack) begin
                    counter_d = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_REFRESH;
                end
            end
            ST_GRANTED: begin
                counter_d = sat_inc(counter_q);
                if (!req[owner_q]) begin
                    // Start the next scan just past the releasing client so others get first pick
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == PW'(Requesters - 1)) ? PW'(0) : owner_q + PW'(1);
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_GRANTED;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            counter_q <= CNT_RESET;
            ref_en_q  <= 1'b0;
            ref_cmd_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            counter_q <= counter_d;
            ref_en_q  <= ref_en_d;
            ref_cmd_q <= ref_cmd_d;
        end
    end

    // Controller-side outputs: owner pass-through while granted, else the registered refresh command
    always_comb begin
        I_sdrc_cmd_en   = 1'b0;
        I_sdrc_cmd      = 3'b000;
        I_sdrc_addr     = 21'd0;
        I_sdrc_data     = 32'd0;
        I_sdrc_data_len = 8'd0;
        c_cmd_ack       = '0;
        if (state_q == ST_GRANTED) begin
            I_sdrc_cmd_en   = sel_cmd_en_s;
            I_sdrc_cmd      = sel_cmd_s;
            I_sdrc_addr     = sel_addr_s;
            I_sdrc_data     = sel_data_s;
            I_sdrc_data_len = sel_len_s;
            c_cmd_ack       = grant_q & {Requesters{O_sdrc_cmd_ack}};
        end else begin
            I_sdrc_cmd_en = ref_en_q;
            I_sdrc_cmd    = ref_cmd_q;
        end
    end

endmodule
